// File: rtl/shift_sub_divider.sv
// 32-bit unsigned restoring divider: one quotient bit per clock, 32 iterations per result.
// A zero divisor skips the iterations and reports all-ones quotient and the dividend as remainder.
module shift_sub_divider (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  iter_cnt;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;
    logic        dbz_q;
    logic        accept;
    logic [32:0] step;

    // The remainder stays below the divisor, so a 33-bit trial difference
    // always fits and its top bit is the borrow.
    function automatic logic [32:0] div_step(input logic [31:0] rem,
                                             input logic        msb,
                                             input logic [31:0] dvsr);
        logic [32:0] shifted;
        logic [32:0] trial;
        shifted = {rem, msb};
        trial   = shifted - {1'b0, dvsr};
        if (!trial[32])
            div_step = {trial[31:0], 1'b1};
        else
            div_step = {shifted[31:0], 1'b0};
    endfunction

    assign accept = (state == IDLE) && i_start;
    assign step   = div_step(rem_q, quo_q[31], dvsr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = (i_divisor == 32'd0) ? DONE : RUN;
            RUN:  if (iter_cnt == 5'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state)
            RUN:  o_busy = 1'b1;
            DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // {rem_q, quo_q} is a single 64-bit shift register; quo_q starts as the dividend.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iter_cnt <= 5'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            iter_cnt <= 5'd0;
            dvsr_q   <= i_divisor;
            if (i_divisor == 32'd0) begin
                quo_q <= 32'hFFFF_FFFF;
                rem_q <= i_dividend;
                dbz_q <= 1'b1;
            end else begin
                quo_q <= i_dividend;
                rem_q <= 32'd0;
                dbz_q <= 1'b0;
            end
        end else if (state == RUN) begin
            rem_q    <= step[32:1];
            quo_q    <= {quo_q[30:0], step[0]};
            iter_cnt <= iter_cnt + 5'd1;
        end
    end

    assign o_quotient    = quo_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: expected results are queued at start and
// compared, together with the completion cycle, whenever o_done pulses.
module tb_shift_sub_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    shift_sub_divider dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int done_cyc);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dbz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 1'b0;
        end
        e.done_cyc = done_cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (o_done) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", o_quotient, e.q);
                check("remainder", o_remainder, e.r);
                check("div_by_zero", {31'd0, o_div_by_zero}, {31'd0, e.dbz});
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("busy_at_done", {31'd0, o_busy}, 32'd0);
            end
        end
    end

    // Call at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        sb.push_back(model(a, b, (b == 32'd0) ? cyc + 1 : cyc + 33));
        @(negedge clk);
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
    endtask

    // Returns at the first negedge where the DUT is back in IDLE.
    task automatic wait_done(input int budget);
        int n = 0;
        #1;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        logic [31:0] a;
        logic [31:0] b;

        reset_n    = 1'b0;
        i_start    = 1'b0;
        i_dividend = 32'd0;
        i_divisor  = 32'd0;
        #1;
        check("rst_quotient", o_quotient, 32'd0);
        check("rst_remainder", o_remainder, 32'd0);
        check("rst_flags", {29'd0, o_busy, o_done, o_div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 100/7 with busy-window measurement
        start_div(32'd100, 32'd7);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_done) break;
            if (o_busy) n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd32);
        check("done_seen", {31'd0, o_done}, 32'd1);
        wait_done(5);
        repeat (3) @(negedge clk);
        check("hold_q", o_quotient, 32'd14);
        check("hold_r", o_remainder, 32'd2);
        check("hold_idle", {30'd0, o_busy, o_done}, 32'd0);

        start_div(32'hFFFF_FFFF, 32'd1);
        wait_done(40);
        start_div(32'd5, 32'd10);
        wait_done(40);

        // zero divisor: result in the cycle after the accept edge, then held
        start_div(32'd1234, 32'd0);
        wait_done(5);
        repeat (4) @(negedge clk);
        check("dbz_hold_q", o_quotient, 32'hFFFF_FFFF);
        check("dbz_hold_r", o_remainder, 32'd1234);
        check("dbz_hold_flag", {31'd0, o_div_by_zero}, 32'd1);
        start_div(32'd6, 32'd3);
        check("dbz_cleared", {31'd0, o_div_by_zero}, 32'd0);
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
        wait_done(40);

        // i_start held high, operands scrambled except at the accept edges
        c0 = cyc;
        for (int k = 0; k < 3; k++) sb.push_back(model(32'd1000, 32'd3, c0 + 33 + 34 * k));
        i_start = 1'b1;
        while (cyc <= c0 + 101) begin
            if (((cyc - c0) % 34) == 0) begin
                i_dividend = 32'd1000;
                i_divisor  = 32'd3;
            end else begin
                i_dividend = $urandom;
                i_divisor  = $urandom;
            end
            if (cyc == c0 + 101) i_start = 1'b0;
            @(negedge clk);
        end
        i_start = 1'b0;
        wait_done(40);

        // reset in the middle of a run: immediate clear and no result
        i_dividend = 32'h8000_0000;
        i_divisor  = 32'd3;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_q", o_quotient, 32'd0);
        check("abort_r", o_remainder, 32'd0);
        check("abort_flags", {29'd0, o_busy, o_done, o_div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_done", {31'd0, o_done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_idle", {31'd0, o_busy}, 32'd0);
        start_div(32'd9, 32'd4);
        wait_done(40);

        for (int i = 0; i < 2000; i++) begin
            case (i % 4)
                0: begin a = $urandom; b = 32'd1; end
                1: begin a = $urandom >> 1; b = a + 32'd1 + 32'($urandom_range(0, 100)); end
                2: begin a = $urandom | 32'd1; b = a; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            start_div(a, b);
            wait_done(40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
